mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_pkg.sv | 19 +
 rtl/load_align.sv | 24 ++
 rtl/mem_stage.sv | 142 ++++++++++++++
 tb/tb_mem_stage.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage: access size encodings, FSM states
// and the default access timeout.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10,
    SZ_RSVD = 2'b11
  } dsize_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam int TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte or half out of a read word and extends it to
// 32 bits (sign or zero); word loads pass straight through.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  dsize_e      dsize,
  input  logic        loadext,
  output logic [31:0] data
);

  logic [15:0] laneHalf;

  always_comb begin
    laneHalf = 16'(rdata >> {addr, 3'b000});
    case (dsize)
      SZ_BYTE: data = {{24{loadext & laneHalf[7]}}, laneHalf[7:0]};
      SZ_HALF: data = {{16{loadext & laneHalf[15]}}, laneHalf};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues one data-memory access at a time, waits for
// ack or timeout, and registers the write-back result.
module mem_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic        memwr,
  input  logic        memtoreg,
  input  logic        regwr,
  input  logic        loadext,
  input  logic        jal,
  input  logic [1:0]  dsize,
  input  logic [4:0]  rw,
  input  logic [31:0] execresult,
  input  logic [31:0] busb,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        mem_stall,
  output logic        wb_valid,
  output logic        wb_regwr,
  output logic [4:0]  wb_rw,
  output logic [31:0] wb_data,
  output logic        mem_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state;
  dsize_e           size;
  logic [CNT_W-1:0] waitCnt;
  logic             memOp, misaligned, waitAck, timeout, fault;
  logic [3:0]       laneBe;
  logic [31:0]      laneData, loadData;

  assign size = dsize_e'(dsize);
  // A link (jal) never touches memory, whatever the other control bits say.
  assign memOp   = in_valid & ~jal & (memwr | memtoreg);
  assign waitAck = (state == WAIT) & dmem_ack;
  assign timeout = (state == WAIT) & ~dmem_ack & (waitCnt == CNT_LAST);
  assign fault   = (state == IDLE) & memOp & misaligned;
  // Stall holds EX/MEM until the cycle in which the access completes.
  assign mem_stall = memOp & ~(waitAck | timeout | fault);

  always_comb begin
    misaligned = 1'b0;
    laneBe     = 4'b1111;
    laneData   = busb;
    case (size)
      SZ_WORD: misaligned = (execresult[1:0] != 2'b00);
      SZ_HALF: begin
        misaligned = execresult[0];
        laneBe     = 4'b0011 << execresult[1:0];
        laneData   = {2{busb[15:0]}};
      end
      SZ_BYTE: begin
        laneBe   = 4'b0001 << execresult[1:0];
        laneData = {4{busb[7:0]}};
      end
      default: misaligned = 1'b1;
    endcase
  end

  load_align uLoadAlign (
    .rdata   (dmem_rdata),
    .addr    (dmem_addr[1:0]),
    .dsize   (size),
    .loadext (loadext),
    .data    (loadData)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      waitCnt    <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= '0;
      wb_valid   <= 1'b0;
      wb_regwr   <= 1'b0;
      wb_rw      <= '0;
      wb_data    <= '0;
      mem_err    <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && !memOp) begin
            wb_valid <= 1'b1;
            wb_regwr <= regwr;
            wb_rw    <= rw;
            wb_data  <= execresult;
          end else if (fault) begin
            wb_valid <= 1'b1;
            wb_regwr <= 1'b0;
            wb_rw    <= rw;
            mem_err  <= 1'b1;
          end else if (memOp) begin
            state      <= WAIT;
            waitCnt    <= '0;
            dmem_req   <= 1'b1;
            dmem_we    <= memwr;
            dmem_addr  <= execresult;
            dmem_wdata <= laneData;
            dmem_be    <= laneBe;
          end
        end
        WAIT: begin
          if (dmem_ack) begin
            state    <= IDLE;
            dmem_req <= 1'b0;
            wb_valid <= 1'b1;
            wb_rw    <= rw;
            wb_regwr <= memwr ? 1'b0 : regwr;
            if (!memwr) wb_data <= loadData;
          end else if (timeout) begin
            state    <= IDLE;
            dmem_req <= 1'b0;
            mem_err  <= 1'b1;
            wb_valid <= 1'b1;
            wb_regwr <= 1'b0;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU/jal pass-through, stores, loads,
// misalignment, timeout and reset during an access.
module tb_mem_stage;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid, memwr, memtoreg, regwr, loadext, jal;
  logic [1:0]  dsize;
  logic [4:0]  rw;
  logic [31:0] execresult, busb;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        mem_stall, wb_valid, wb_regwr;
  logic [4:0]  wb_rw;
  logic [31:0] wb_data;
  logic        mem_err;

  int checks = 0;
  int failures = 0;

  mem_stage #(.TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .memwr(memwr),
    .memtoreg(memtoreg), .regwr(regwr), .loadext(loadext), .jal(jal),
    .dsize(dsize), .rw(rw), .execresult(execresult), .busb(busb),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .mem_stall(mem_stall), .wb_valid(wb_valid),
    .wb_regwr(wb_regwr), .wb_rw(wb_rw), .wb_data(wb_data), .mem_err(mem_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idleInputs();
    in_valid = 0; memwr = 0; memtoreg = 0; regwr = 0; loadext = 0; jal = 0;
    dsize = 2'b00; rw = 0; execresult = 0; busb = 0; dmem_ack = 0;
  endtask

  initial begin
    idleInputs();
    dmem_rdata = 0;
    reset_n = 0;
    #12;
    check("rst_req", 32'(dmem_req), 0);
    check("rst_wbvalid", 32'(wb_valid), 0);
    check("rst_err", 32'(mem_err), 0);
    check("rst_be", 32'(dmem_be), 0);
    check("rst_wbdata", wb_data, 0);
    check("rst_stall", 32'(mem_stall), 0);
    @(negedge clock); reset_n = 1;
    step();

    // ALU op
    in_valid = 1; regwr = 1; rw = 3; execresult = 32'd8;
    #1 check("alu_stall", 32'(mem_stall), 0);
    step();
    check("alu_wbvalid", 32'(wb_valid), 1);
    check("alu_wbrw", 32'(wb_rw), 3);
    check("alu_wbdata", wb_data, 8);
    check("alu_wbregwr", 32'(wb_regwr), 1);
    idleInputs();
    step();
    check("idle_wbvalid", 32'(wb_valid), 0);

    // jal with stray memtoreg: link passes through, no memory access
    in_valid = 1; jal = 1; memtoreg = 1; regwr = 1; rw = 31; execresult = 32'h1234;
    step();
    check("jal_wbdata", wb_data, 32'h1234);
    check("jal_req", 32'(dmem_req), 0);
    idleInputs();
    step();

    // Byte store at 0x102, ack on the third WAIT cycle
    in_valid = 1; memwr = 1; dsize = 2'b10; execresult = 32'h102; busb = 32'hAB; rw = 7;
    #1 check("sb_stall_issue", 32'(mem_stall), 1);
    step();
    check("sb_req", 32'(dmem_req), 1);
    check("sb_we", 32'(dmem_we), 1);
    check("sb_be", 32'(dmem_be), 32'b0100);
    check("sb_wdata", dmem_wdata, 32'hABABABAB);
    check("sb_addr", dmem_addr, 32'h102);
    check("sb_wbvalid_wait", 32'(wb_valid), 0);
    step();
    step();
    check("sb_stall_wait", 32'(mem_stall), 1);
    dmem_ack = 1;
    #1 check("sb_stall_ack", 32'(mem_stall), 0);
    step();
    check("sb_req_drop", 32'(dmem_req), 0);
    check("sb_wbvalid", 32'(wb_valid), 1);
    check("sb_wbregwr", 32'(wb_regwr), 0);
    idleInputs();
    step();

    // Back-to-back half loads at 0x2: sign-extended then zero-extended
    in_valid = 1; memtoreg = 1; dsize = 2'b01; execresult = 32'h2; regwr = 1; rw = 5; loadext = 1;
    step();
    check("lh_req", 32'(dmem_req), 1);
    check("lh_we", 32'(dmem_we), 0);
    dmem_ack = 1; dmem_rdata = 32'h8001_0000;
    step();
    check("lh_sext", wb_data, 32'hFFFF_8001);
    check("lh_regwr", 32'(wb_regwr), 1);
    check("lh_rw", 32'(wb_rw), 5);
    dmem_ack = 0; loadext = 0;
    step();
    check("lhu_req", 32'(dmem_req), 1);
    check("lhu_wbvalid_issue", 32'(wb_valid), 0);
    dmem_ack = 1;
    step();
    check("lhu_zext", wb_data, 32'h0000_8001);
    check("lhu_wbvalid", 32'(wb_valid), 1);
    idleInputs();
    dmem_ack = 1;
    step();
    check("ack_idle_ignored", 32'(wb_valid), 0);
    dmem_ack = 0;

    // Misaligned word load at 0x6
    in_valid = 1; memtoreg = 1; dsize = 2'b00; execresult = 32'h6; regwr = 1; rw = 9;
    step();
    check("mis_req", 32'(dmem_req), 0);
    check("mis_err", 32'(mem_err), 1);
    check("mis_wbvalid", 32'(wb_valid), 1);
    check("mis_wbregwr", 32'(wb_regwr), 0);
    idleInputs();
    step();
    check("err_sticky", 32'(mem_err), 1);

    // Clear the sticky error before the timeout case
    @(negedge clock); reset_n = 0;
    #1 check("rst2_err", 32'(mem_err), 0);
    @(negedge clock); reset_n = 1;
    step();

    // Load with no ack: exactly 16 WAIT cycles then abort
    in_valid = 1; memtoreg = 1; dsize = 2'b00; execresult = 32'h10; regwr = 1; rw = 4;
    step();
    check("to_req_issue", 32'(dmem_req), 1);
    for (int i = 0; i < 15; i++) begin
      step();
      check("to_req_hold", 32'(dmem_req), 1);
      check("to_wbvalid_hold", 32'(wb_valid), 0);
    end
    check("to_stall_release", 32'(mem_stall), 0);
    step();
    check("to_req_drop", 32'(dmem_req), 0);
    check("to_err", 32'(mem_err), 1);
    check("to_wbvalid", 32'(wb_valid), 1);
    check("to_wbregwr", 32'(wb_regwr), 0);
    idleInputs();
    step();

    // Reset pulse during WAIT abandons the access
    in_valid = 1; memtoreg = 1; dsize = 2'b00; execresult = 32'h20; regwr = 1; rw = 2;
    step();
    check("rw_req", 32'(dmem_req), 1);
    step();
    @(negedge clock); reset_n = 0;
    #1;
    check("rw_req_async", 32'(dmem_req), 0);
    check("rw_wbvalid", 32'(wb_valid), 0);
    idleInputs();
    @(negedge clock); reset_n = 1;
    step();
    check("rw_wbvalid_after", 32'(wb_valid), 0);
    check("rw_req_after", 32'(dmem_req), 0);
    // IDLE confirmed: an ALU op completes in one cycle
    in_valid = 1; regwr = 1; rw = 6; execresult = 32'hCAFE;
    step();
    check("rw_idle_alu", wb_data, 32'hCAFE);

    // Reserved size: no request, error, single-cycle completion
    in_valid = 1; memwr = 1; regwr = 0; dsize = 2'b11; execresult = 32'h40; busb = 32'h55;
    step();
    check("rsvd_req", 32'(dmem_req), 0);
    check("rsvd_err", 32'(mem_err), 1);
    check("rsvd_wbvalid", 32'(wb_valid), 1);
    idleInputs();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
